// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch/data) arbiter onto a shared ROM/RAM bus with per-region wait states.
// Round-robin on ties; ROM writes are rejected with d_err without touching the bus.
module mem_bus_arbiter #(
   parameter int ROM_WAIT = 2,
   parameter int RAM_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        f_req,
   input  logic [12:0] f_addr,
   output logic        f_ack,
   output logic [7:0]  f_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [12:0] d_addr,
   input  logic [7:0]  d_wdata,
   output logic        d_ack,
   output logic [7:0]  d_rdata,
   output logic        d_err,
   output logic [12:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        rom_sel,
   output logic        ram_sel,
   output logic        mem_rd,
   output logic        mem_wr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state, state_n;
   logic [2:0]  count, count_n;
   logic        last_data, last_data_n;
   logic        gnt_data, gnt_data_n;
   logic [12:0] mem_addr_n;
   logic [7:0]  mem_wdata_n, f_rdata_n, d_rdata_n;
   logic        rom_sel_n, ram_sel_n, mem_rd_n, mem_wr_n;
   logic        f_ack_n, d_ack_n, d_err_n;
   logic        pick_data, req_we, req_ram;
   logic [12:0] req_addr;

   always_comb begin
      state_n     = state;
      count_n     = count;
      last_data_n = last_data;
      gnt_data_n  = gnt_data;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      f_rdata_n   = f_rdata;
      d_rdata_n   = d_rdata;
      rom_sel_n   = 1'b0;
      ram_sel_n   = 1'b0;
      mem_rd_n    = 1'b0;
      mem_wr_n    = 1'b0;
      f_ack_n     = 1'b0;
      d_ack_n     = 1'b0;
      d_err_n     = 1'b0;

      // On a tie the port that did not win last time is granted.
      pick_data = d_req & (~f_req | ~last_data);
      req_addr  = pick_data ? d_addr : f_addr;
      req_we    = pick_data & d_we;
      req_ram   = (req_addr[12:11] == 2'b11);

      case (state)
         IDLE: begin
            if (f_req | d_req) begin
               last_data_n = pick_data;
               gnt_data_n  = pick_data;
               mem_addr_n  = req_addr;
               if (pick_data) begin
                  mem_wdata_n = d_wdata;
               end
               if (req_we && !req_ram) begin
                  state_n = DONE;
                  d_ack_n = 1'b1;
                  d_err_n = 1'b1;
               end else begin
                  state_n   = ACCESS;
                  count_n   = req_ram ? 3'(RAM_WAIT) : 3'(ROM_WAIT);
                  rom_sel_n = ~req_ram;
                  ram_sel_n = req_ram;
                  mem_rd_n  = ~req_we;
                  mem_wr_n  = req_we;
               end
            end
         end
         ACCESS: begin
            if (count <= 3'd1) begin
               state_n = DONE;
               count_n = '0;
               if (gnt_data) begin
                  d_ack_n   = 1'b1;
                  d_rdata_n = mem_rdata;
               end else begin
                  f_ack_n   = 1'b1;
                  f_rdata_n = mem_rdata;
               end
            end else begin
               count_n   = count - 3'd1;
               rom_sel_n = rom_sel;
               ram_sel_n = ram_sel;
               mem_rd_n  = mem_rd;
               mem_wr_n  = mem_wr;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         last_data <= 1'b1;
         gnt_data  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         f_rdata   <= '0;
         d_rdata   <= '0;
         rom_sel   <= 1'b0;
         ram_sel   <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         f_ack     <= 1'b0;
         d_ack     <= 1'b0;
         d_err     <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         last_data <= last_data_n;
         gnt_data  <= gnt_data_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         f_rdata   <= f_rdata_n;
         d_rdata   <= d_rdata_n;
         rom_sel   <= rom_sel_n;
         ram_sel   <= ram_sel_n;
         mem_rd    <= mem_rd_n;
         mem_wr    <= mem_wr_n;
         f_ack     <= f_ack_n;
         d_ack     <= d_ack_n;
         d_err     <= d_err_n;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level timeline model (queue of future cycles)
// compared every cycle, plus directed transactions with literal expectations.
module tb_mem_bus_arbiter;

   localparam int ROM_W = 2;
   localparam int RAM_W = 1;

   logic        clk = 1'b0;
   logic        rst, f_req, d_req, d_we;
   logic [12:0] f_addr, d_addr;
   logic [7:0]  d_wdata, mem_rdata;
   logic        f_ack, d_ack, d_err, rom_sel, ram_sel, mem_rd, mem_wr;
   logic [7:0]  f_rdata, d_rdata, mem_wdata;
   logic [12:0] mem_addr;

   mem_bus_arbiter #(.ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .rom_sel(rom_sel), .ram_sel(ram_sel), .mem_rd(mem_rd), .mem_wr(mem_wr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rom_sel, ram_sel, rd, wr, f_ack, d_ack, d_err;
      logic        chk_addr, chk_wdata, capture, cap_data;
      logic [12:0] addr;
      logic [7:0]  wdata;
   } ent_t;

   ent_t       q[$];
   ent_t       exp_e;
   logic [7:0] m_frd, m_drd;
   logic       last_data;
   bit         check_en = 1'b0;
   int         checks = 0;
   int         failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Expand one granted transaction into the outputs of every cycle it occupies.
   task automatic schedule();
      ent_t        e;
      logic        pd, ram, we;
      logic [12:0] a;
      int          nw;
      pd = d_req && (!f_req || !last_data);
      last_data = pd;
      a   = pd ? d_addr : f_addr;
      ram = (a >= 13'h1800);
      we  = pd && d_we;
      if (we && !ram) begin
         e = '0; e.d_ack = 1'b1; e.d_err = 1'b1;
         q.push_back(e);
      end else begin
         nw = ram ? RAM_W : ROM_W;
         for (int i = 0; i < nw; i++) begin
            e = '0;
            e.rom_sel = !ram; e.ram_sel = ram; e.rd = !we; e.wr = we;
            e.chk_addr = 1'b1; e.addr = a; e.chk_wdata = we; e.wdata = d_wdata;
            q.push_back(e);
         end
         e = '0; e.f_ack = !pd; e.d_ack = pd; e.capture = 1'b1; e.cap_data = pd;
         q.push_back(e);
      end
      e = '0;
      q.push_back(e);
   endtask

   // Advance one cycle; inputs still hold the previous cycle's values at this point.
   task automatic step();
      ent_t e;
      @(posedge clk);
      #1;
      e = '0;
      if (rst) begin
         q.delete();
         last_data = 1'b1;
         m_frd = '0;
         m_drd = '0;
         e.chk_addr = 1'b1; e.chk_wdata = 1'b1;
      end else begin
         if (q.size() == 0 && (f_req || d_req)) schedule();
         if (q.size() != 0) e = q.pop_front();
         if (e.capture) begin
            if (e.cap_data) m_drd = mem_rdata;
            else m_frd = mem_rdata;
         end
      end
      exp_e = e;
      check_en = 1'b1;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("rom_sel", rom_sel, exp_e.rom_sel);
         chk("ram_sel", ram_sel, exp_e.ram_sel);
         chk("mem_rd", mem_rd, exp_e.rd);
         chk("mem_wr", mem_wr, exp_e.wr);
         chk("f_ack", f_ack, exp_e.f_ack);
         chk("d_ack", d_ack, exp_e.d_ack);
         chk("d_err", d_err, exp_e.d_err);
         chk("f_rdata", f_rdata, m_frd);
         chk("d_rdata", d_rdata, m_drd);
         if (exp_e.chk_addr) chk("mem_addr", mem_addr, exp_e.addr);
         if (exp_e.chk_wdata) chk("mem_wdata", mem_wdata, exp_e.wdata);
      end
   end

   task automatic txn(input bit is_d, input bit we, input logic [12:0] a, input logic [7:0] wd,
                      input logic [7:0] rd, input int nw, input bit ram, input bit err);
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
      end else begin
         f_req = 1'b1; f_addr = a;
      end
      mem_rdata = rd;
      if (!err) begin
         for (int i = 0; i < nw; i++) begin
            step();
            chk("lit_rom_sel", rom_sel, !ram);
            chk("lit_ram_sel", ram_sel, ram);
            chk("lit_mem_rd", mem_rd, !we);
            chk("lit_mem_wr", mem_wr, we);
            chk("lit_mem_addr", mem_addr, a);
            chk("lit_early_ack", f_ack | d_ack, 0);
            if (we) chk("lit_mem_wdata", mem_wdata, wd);
         end
      end
      step();
      chk("lit_ack", is_d ? d_ack : f_ack, 1);
      chk("lit_other_ack", is_d ? f_ack : d_ack, 0);
      chk("lit_d_err", d_err, err);
      chk("lit_done_bus_idle", {rom_sel, ram_sel, mem_rd, mem_wr}, 0);
      if (!we) chk("lit_rdata", is_d ? d_rdata : f_rdata, rd);
      step();
      f_req = 1'b0;
      d_req = 1'b0;
      step();
   endtask

   logic [12:0] ra;
   bit          f_pend, f_drop, d_pend, d_drop;
   int          nacks;
   logic [3:0]  seq;

   initial begin
      rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      step();
      chk("rst_outputs", {f_ack, d_ack, d_err, rom_sel, ram_sel, mem_rd, mem_wr}, 0);
      chk("rst_rdata", {f_rdata, d_rdata}, 0);
      chk("rst_bus", {mem_addr, mem_wdata}, 0);
      rst = 1'b0;
      step();

      txn(0, 0, 13'h0010, 8'h00, 8'hA5, 2, 0, 0);
      txn(1, 1, 13'h1805, 8'h3C, 8'h00, 1, 1, 0);
      txn(1, 1, 13'h1000, 8'h77, 8'h11, 0, 0, 1);
      txn(0, 0, 13'h17FF, 8'h00, 8'h21, 2, 0, 0);
      txn(1, 0, 13'h1800, 8'h00, 8'h42, 1, 1, 0);
      txn(0, 0, 13'h1FFF, 8'h00, 8'h63, 1, 1, 0);
      txn(1, 0, 13'h0FFF, 8'h00, 8'h84, 2, 0, 0);

      // Both ports held continuously after reset: grants must alternate starting with fetch.
      rst = 1'b1;
      step();
      rst = 1'b0;
      f_req = 1'b1; f_addr = 13'h1900;
      d_req = 1'b1; d_we = 1'b0; d_addr = 13'h0100;
      mem_rdata = 8'h9E;
      nacks = 0;
      seq = '0;
      for (int c = 0; c < 40 && nacks < 4; c++) begin
         step();
         chk("ack_overlap", f_ack & d_ack, 0);
         if (f_ack || d_ack) begin
            seq[nacks] = d_ack;
            nacks++;
         end
      end
      f_req = 1'b0;
      d_req = 1'b0;
      chk("rr_ack_count", nacks, 4);
      chk("rr_order", seq, 4'b1010);
      step();
      step();

      // Reset in the second ROM access cycle aborts the fetch.
      f_req = 1'b1; f_addr = 13'h0010; mem_rdata = 8'h5A;
      step();
      step();
      chk("abort_pre_rom_sel", rom_sel, 1);
      rst = 1'b1;
      step();
      chk("abort_outputs", {f_ack, d_ack, d_err, rom_sel, ram_sel, mem_rd, mem_wr}, 0);
      chk("abort_rdata", {f_rdata, d_rdata}, 0);
      rst = 1'b0;
      f_req = 1'b0;
      step();
      chk("abort_no_ack", f_ack, 0);
      txn(0, 0, 13'h0010, 8'h00, 8'hC3, 2, 0, 0);

      f_pend = 0; f_drop = 0; d_pend = 0; d_drop = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         rst = ($urandom_range(0, 299) == 0);
         mem_rdata = 8'($urandom);
         if (rst) begin
            f_req = 1'b0; d_req = 1'b0;
            f_pend = 0; d_pend = 0; f_drop = 0; d_drop = 0;
         end else begin
            if (exp_e.f_ack) f_drop = 1;
            else if (f_drop) begin
               f_drop = 0; f_pend = 0; f_req = 1'b0;
            end else if (!f_pend && $urandom_range(0, 2) == 0) begin
               ra = 13'($urandom);
               if ($urandom_range(0, 1) == 0) ra = 13'h1800 | (ra & 13'h07FF);
               f_pend = 1; f_req = 1'b1; f_addr = ra;
            end
            if (!f_pend) f_addr = 13'($urandom);

            if (exp_e.d_ack) d_drop = 1;
            else if (d_drop) begin
               d_drop = 0; d_pend = 0; d_req = 1'b0;
            end else if (!d_pend && $urandom_range(0, 2) == 0) begin
               ra = 13'($urandom);
               if ($urandom_range(0, 1) == 0) ra = 13'h1800 | (ra & 13'h07FF);
               d_pend = 1; d_req = 1'b1; d_addr = ra;
               d_we = 1'($urandom); d_wdata = 8'($urandom);
            end
            if (!d_pend) begin
               d_addr = 13'($urandom); d_we = 1'($urandom); d_wdata = 8'($urandom);
            end
         end
      end
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ROM_WAIT, default 2: ROM access cycles (legal 1..7).
REQ-002 Parameter RAM_WAIT, default 1: RAM access cycles (legal 1..7).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 f_req  input  1  instruction-fetch request (read only).
REQ-006 f_addr  input  13  fetch address.
REQ-007 f_ack  output  1  one-cycle fetch completion pulse.
REQ-008 f_rdata  output  8  fetch read data, valid while f_ack=1.
REQ-009 d_req  input  1  data-port request.
REQ-010 d_we  input  1  data-port write (1) / read (0).
REQ-011 d_addr  input  13  data-port address.
REQ-012 d_wdata  input  8  data-port write data.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 d_rdata  output  8  data read data, valid while d_ack=1.
REQ-015 d_err  output  1  pulses with d_ack when a write targeted ROM.
REQ-016 mem_addr  output  13  shared memory address.
REQ-017 mem_wdata  output  8  shared write data.
REQ-018 mem_rdata  input  8  read data from selected device.
REQ-019 rom_sel, ram_sel  output  1 each  device selects.
REQ-020 mem_rd, mem_wr  output  1 each  read/write strobes.

Function
REQ-021 Memory map SHALL be: addr[12]=0 or addr[12:11]=2'b10 -> ROM; addr[12:11]=2'b11 -> RAM; rom_sel and ram_sel never both 1.
REQ-022 States SHALL be IDLE, ACCESS, DONE; all outputs registered.
REQ-023 IDLE: no request -> stay IDLE, all selects/strobes 0.
REQ-024 IDLE, one request -> grant it; latch addr, we, wdata, region; go ACCESS with count = region wait value.
REQ-025 IDLE, both requests -> round-robin: grant the port not granted last; last_grant updates on every grant.
REQ-026 ACCESS: mem_addr/mem_wdata hold latched values; selected device's sel=1; mem_rd=1 for reads, mem_wr=1 for writes; held for exactly WAIT consecutive cycles.
REQ-027 Last ACCESS cycle: mem_rdata captured into granted port's rdata register at the edge leaving ACCESS; go DONE.
REQ-028 DONE: granted port's ack=1 for exactly one cycle, sel/strobes 0; next state IDLE unconditionally.
REQ-029 Latency SHALL be: request seen in IDLE cycle n -> ACCESS cycles n+1..n+WAIT -> ack in cycle n+WAIT+1.
REQ-030 Data write to ROM region SHALL skip ACCESS: IDLE -> DONE, d_ack=1 and d_err=1 same cycle, no mem_wr, no sel.
REQ-031 Fetch and data reads from either region SHALL be legal; d_err=0 for all other accesses.
REQ-032 Requesters hold req and inputs stable until ack; req deasserts the cycle after ack; any req=1 in IDLE is a new request.
REQ-033 Inputs changing during ACCESS/DONE SHALL not affect the access in progress.
REQ-034 rdata registers SHALL hold last captured value until next completion for that port.
REQ-035 f_ack and d_ack SHALL never be 1 in the same cycle.

Reset
REQ-036 rst=1 at an edge SHALL force IDLE, count=0, last_grant=data (fetch wins first tie), all outputs incl. rdata registers to 0.
REQ-037 rst mid-ACCESS or DONE SHALL abort; no ack issued for the aborted access; strobes 0 the next cycle.

Verification
REQ-038 Fetch 13'h0010, mem_rdata=8'hA5, defaults -> rom_sel=1, mem_rd=1 two cycles; f_ack cycle n+3, f_rdata=8'hA5.
REQ-039 Data write 13'h1805, d_wdata=8'h3C -> ram_sel=1, mem_wr=1, mem_wdata=8'h3C one cycle; d_ack cycle n+2, d_err=0.
REQ-040 Data write 13'h1000 (ROM) -> d_ack=1, d_err=1 cycle n+1; mem_wr, rom_sel stay 0.
REQ-041 f_req and d_req held continuously after reset -> grants alternate fetch, data, fetch, data; acks never overlap.
REQ-042 Boundaries: read 13'h17FF -> rom_sel; read 13'h1800 -> ram_sel; read 13'h1FFF -> ram_sel.
REQ-043 rst=1 in second ROM ACCESS cycle -> no f_ack; all outputs 0 next cycle; fresh request after reset completes normally.
